// File: rtl/sobel_pkg.sv
// Shared types for the window fetch controller: shift directions, FSM states,
// batch kinds and the pixel width.
package sobel_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        SH_NONE  = 2'b00,
        SH_LEFT  = 2'b01,
        SH_RIGHT = 2'b10,
        SH_UP    = 2'b11
    } sh_dir_t;

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        WAIT_MEM,
        PUSH,
        WAIT_RD,
        PRESENT,
        SHIFT,
        WAIT_SH,
        DONE
    } wf_state_t;

    typedef enum logic [1:0] {
        B_INIT,
        B_COL,
        B_ROW
    } batch_t;

endpackage

// File: rtl/wf_addr_gen.sv
// Serpentine walk bookkeeping: window top-left row/col, position inside the
// current fetch batch, scan direction, and the resulting pixel address.
module wf_addr_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    localparam int RW = $clog2(IMG_H),
    localparam int CW = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              init_i,
    input  logic              adv_i,
    input  logic              shift_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              batch_last_o,
    output logic              last_win_o,
    output sh_dir_t           shift_dir_o,
    output logic [RW-1:0]     row_o,
    output logic [CW-1:0]     col_o
);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [1:0]    kr_q, kr_d, kc_q, kc_d;
    logic          right_q, right_d;
    batch_t        mode_q, mode_d;
    logic          pass_end;
    logic [ADDR_W-1:0] pix_r, pix_c;

    assign pass_end    = right_q ? (col_q == CW'(IMG_W - 3)) : (col_q == '0);
    assign last_win_o  = pass_end && (row_q == RW'(IMG_H - 3));
    assign row_o       = row_q;
    assign col_o       = col_q;
    // Reflects the shift that produced the current batch.
    assign shift_dir_o = (mode_q == B_ROW) ? SH_UP : (right_q ? SH_LEFT : SH_RIGHT);

    always_comb begin
        batch_last_o = 1'b0;
        pix_r = ADDR_W'(row_q) + ADDR_W'(2) - ADDR_W'(kr_q);
        pix_c = ADDR_W'(col_q) + ADDR_W'(kc_q);
        case (mode_q)
            B_INIT:  batch_last_o = (kr_q == 2'd2) && (kc_q == 2'd2);
            B_COL: begin
                batch_last_o = (kr_q == 2'd2);
                pix_c = right_q ? ADDR_W'(col_q) + ADDR_W'(2) : ADDR_W'(col_q);
            end
            default: batch_last_o = (kc_q == 2'd2);
        endcase
        addr_o = ADDR_W'(BASE_ADDR) + pix_r * ADDR_W'(IMG_W) + pix_c;
    end

    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        right_d = right_q;
        mode_d  = mode_q;
        if (init_i) begin
            row_d   = '0;
            col_d   = '0;
            kr_d    = '0;
            kc_d    = '0;
            right_d = 1'b1;
            mode_d  = B_INIT;
        end else if (shift_i) begin
            kr_d = '0;
            kc_d = '0;
            if (pass_end) begin
                row_d   = row_q + RW'(1);
                right_d = ~right_q;
                mode_d  = B_ROW;
            end else begin
                col_d  = right_q ? col_q + CW'(1) : col_q - CW'(1);
                mode_d = B_COL;
            end
        end else if (adv_i) begin
            case (mode_q)
                B_INIT: begin
                    if (kc_q == 2'd2) begin
                        kc_d = '0;
                        kr_d = kr_q + 2'd1;
                    end else begin
                        kc_d = kc_q + 2'd1;
                    end
                end
                B_COL:   kr_d = kr_q + 2'd1;
                default: kc_d = kc_q + 2'd1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            row_q   <= '0;
            col_q   <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
            right_q <= 1'b1;
            mode_q  <= B_INIT;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            kr_q    <= kr_d;
            kc_q    <= kc_d;
            right_q <= right_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: rtl/window_fetch_ctrl.sv
// Initiator for the windowBuffer: fetches pixels, sequences shifts and presents
// 3x3 windows in serpentine order. WINFETCH_PERF_EN adds stall/wait counters.
//
// state    | meaning
// IDLE     | waiting for start
// REQ      | issue one memory read
// WAIT_MEM | waiting for mem_rvalid
// PUSH     | hand pixel to windowBuffer
// WAIT_RD  | waiting for read_done
// PRESENT  | window valid, waiting for proc_ready
// SHIFT    | issue window shift
// WAIT_SH  | waiting for shift_done
// DONE     | frame finished, done pulse
module window_fetch_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    localparam int RW = $clog2(IMG_H),
    localparam int CW = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              start_read,
    output logic [PIX_W-1:0]  data_r,
    input  logic              read_done,
    output logic              start_shift,
    output logic [1:0]        shift_direc,
    input  logic              shift_done,
    output logic              window_valid,
    output logic [RW-1:0]     win_row,
    output logic [CW-1:0]     win_col,
    input  logic              proc_ready,
    output logic [31:0]       mem_wait_cycles,
    output logic [31:0]       stall_cycles
);

    wf_state_t         state_q, state_d;
    logic [PIX_W-1:0]  data_q, data_d;
    logic [RW-1:0]     win_row_q, win_row_d;
    logic [CW-1:0]     win_col_q, win_col_d;
    logic              gen_init, gen_adv, gen_shift;
    logic [ADDR_W-1:0] gen_addr;
    logic              batch_last, last_win;
    sh_dir_t           gen_dir;
    logic [RW-1:0]     gen_row;
    logic [CW-1:0]     gen_col;

    wf_addr_gen #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)
    ) u_addr_gen (
        .clk          (clk),
        .n_rst        (n_rst),
        .init_i       (gen_init),
        .adv_i        (gen_adv),
        .shift_i      (gen_shift),
        .addr_o       (gen_addr),
        .batch_last_o (batch_last),
        .last_win_o   (last_win),
        .shift_dir_o  (gen_dir),
        .row_o        (gen_row),
        .col_o        (gen_col)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        gen_init  = 1'b0;
        gen_adv   = 1'b0;
        gen_shift = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                gen_init = 1'b1;
                state_d  = REQ;
            end
            REQ:      state_d = WAIT_MEM;
            WAIT_MEM: if (mem_rvalid) begin
                data_d  = mem_rdata;
                state_d = PUSH;
            end
            PUSH:     state_d = WAIT_RD;
            WAIT_RD: if (read_done) begin
                if (batch_last) begin
                    win_row_d = gen_row + RW'(1);
                    win_col_d = gen_col + CW'(1);
                    state_d   = PRESENT;
                end else begin
                    gen_adv = 1'b1;
                    state_d = REQ;
                end
            end
            PRESENT: if (proc_ready) begin
                if (last_win) begin
                    state_d = DONE;
                end else begin
                    gen_shift = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT:    state_d = WAIT_SH;
            WAIT_SH:  if (shift_done) state_d = REQ;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            win_row_q <= '0;
            win_col_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
        end
    end

    // Address is only driven while a request is outstanding so idle reads as 0.
    assign mem_ren      = (state_q == REQ);
    assign mem_addr     = (state_q == REQ || state_q == WAIT_MEM) ? gen_addr : '0;
    assign start_read   = (state_q == PUSH);
    assign data_r       = data_q;
    assign start_shift  = (state_q == SHIFT);
    assign shift_direc  = (state_q == SHIFT || state_q == WAIT_SH) ? gen_dir : SH_NONE;
    assign window_valid = (state_q == PRESENT);
    assign win_row      = win_row_q;
    assign win_col      = win_col_q;
    assign busy         = (state_q != IDLE) && (state_q != DONE);
    assign done         = (state_q == DONE);

`ifdef WINFETCH_PERF_EN
    logic [31:0] mem_wait_q, stall_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            mem_wait_q <= '0;
            stall_q    <= '0;
        end else if (state_q == IDLE && start) begin
            mem_wait_q <= '0;
            stall_q    <= '0;
        end else begin
            if (state_q == WAIT_MEM && mem_wait_q != '1)
                mem_wait_q <= mem_wait_q + 32'd1;
            if (state_q == PRESENT && !proc_ready && stall_q != '1)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign mem_wait_cycles = mem_wait_q;
    assign stall_cycles    = stall_q;
`else
    assign mem_wait_cycles = '0;
    assign stall_cycles    = '0;
`endif

endmodule
